// File: rtl/ccff_wb_loader.sv
// Wishbone slave that serialises 32-bit words onto an FPGA configuration chain.
// It generates prog_clk from a divided system clock and captures the chain tail.
module ccff_wb_loader #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        prog_clk_o,
    output logic        ccff_head_o,
    input  logic        ccff_tail_i,
    output logic        prog_reset_o,
    output logic        busy_o
);

    localparam logic [7:0]  HC_LAST  = 8'(CLK_DIV - 1);
    localparam logic [2:0]  A_CTRL   = 3'd0;
    localparam logic [2:0]  A_DATA   = 3'd1;
    localparam logic [2:0]  A_STATUS = 3'd2;
    localparam logic [2:0]  A_COUNT  = 3'd3;
    localparam logic [2:0]  A_TAIL   = 3'd4;
    localparam logic [31:0] BAD_RD   = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOW,
        S_HIGH
    } state_t;

    state_t      state_q;
    logic [7:0]  hc_q;
    logic [4:0]  bc_q;
    logic [4:0]  len_q;
    logic [31:0] sr_q;
    logic [31:0] count_q;
    logic [31:0] tail_q;
    logic        prog_rst_q;
    logic        ack_q;
    logic [31:0] dat_q;
    logic        prog_clk_q;
    logic        head_q;
    logic        busy_q;

    logic [2:0]  reg_sel;
    logic        req;
    logic        data_wr;
    logic        accept;
    logic        wr_acc;
    logic        start;
    logic        ctrl_wr;
    logic        abort;
    logic        count_clr;
    logic        rise;
    logic [31:0] rdata;

    // Bits of the bus that carry no information for this block.
    logic        unused_bits;
    assign unused_bits = ^{wbs_sel_i, wbs_adr_i[31:5], wbs_adr_i[1:0]};

    assign reg_sel   = wbs_adr_i[4:2];
    assign req       = wbs_stb_i & wbs_cyc_i & ~ack_q;
    assign data_wr   = wbs_we_i && (reg_sel == A_DATA);
    // A new word can only be taken once the previous one has fully drained.
    assign accept    = req && !(data_wr && (state_q != S_IDLE));
    assign wr_acc    = accept && wbs_we_i;
    assign start     = wr_acc && (reg_sel == A_DATA);
    assign ctrl_wr   = wr_acc && (reg_sel == A_CTRL);
    assign abort     = ctrl_wr && wbs_dat_i[31];
    assign count_clr = wr_acc && (reg_sel == A_COUNT);
    assign rise      = !abort && (state_q == S_LOW) && (hc_q == HC_LAST);

    always_comb begin
        rdata = BAD_RD;
        case (reg_sel)
            A_CTRL:   rdata = {19'd0, len_q, 7'd0, prog_rst_q};
            A_STATUS: rdata = {31'd0, busy_q};
            A_COUNT:  rdata = count_q;
            A_TAIL:   rdata = tail_q;
            default:  rdata = BAD_RD;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q    <= S_IDLE;
            hc_q       <= '0;
            bc_q       <= '0;
            len_q      <= 5'd31;
            sr_q       <= '0;
            count_q    <= '0;
            tail_q     <= '0;
            prog_rst_q <= 1'b1;
            ack_q      <= 1'b0;
            dat_q      <= '0;
            prog_clk_q <= 1'b0;
            head_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            ack_q <= accept;
            if (accept && !wbs_we_i) begin
                dat_q <= rdata;
            end
            if (ctrl_wr) begin
                prog_rst_q <= wbs_dat_i[0];
                len_q      <= wbs_dat_i[12:8];
            end

            // Clear beats a coincident prog_clk rising edge.
            if (count_clr) begin
                count_q <= '0;
            end else if (rise) begin
                count_q <= count_q + 32'd1;
            end
            if (rise) begin
                tail_q <= {ccff_tail_i, tail_q[31:1]};
            end

            if (abort) begin
                state_q    <= S_IDLE;
                hc_q       <= '0;
                prog_clk_q <= 1'b0;
                busy_q     <= 1'b0;
                head_q     <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            sr_q    <= wbs_dat_i;
                            head_q  <= wbs_dat_i[0];
                            bc_q    <= len_q;
                            hc_q    <= '0;
                            busy_q  <= 1'b1;
                            state_q <= S_LOW;
                        end
                    end
                    S_LOW: begin
                        if (hc_q == HC_LAST) begin
                            prog_clk_q <= 1'b1;
                            hc_q       <= '0;
                            state_q    <= S_HIGH;
                        end else begin
                            hc_q <= hc_q + 8'd1;
                        end
                    end
                    S_HIGH: begin
                        if (hc_q == HC_LAST) begin
                            prog_clk_q <= 1'b0;
                            hc_q       <= '0;
                            if (bc_q == 5'd0) begin
                                busy_q  <= 1'b0;
                                state_q <= S_IDLE;
                            end else begin
                                sr_q    <= {1'b0, sr_q[31:1]};
                                head_q  <= sr_q[1];
                                bc_q    <= bc_q - 5'd1;
                                state_q <= S_LOW;
                            end
                        end else begin
                            hc_q <= hc_q + 8'd1;
                        end
                    end
                    default: begin
                        state_q    <= S_IDLE;
                        prog_clk_q <= 1'b0;
                        busy_q     <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign wbs_ack_o    = ack_q;
    assign wbs_dat_o    = dat_q;
    assign prog_clk_o   = prog_clk_q;
    assign ccff_head_o  = head_q;
    assign prog_reset_o = prog_rst_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_ccff_wb_loader.sv
// Directed bench for ccff_wb_loader: bus reads are scoreboarded and checked on ack,
// shift behaviour is checked from recorded prog_clk rising edges.
module tb_ccff_wb_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'hF;
    logic [31:0] adr = '0, dat_i = '0;
    logic        ack;
    logic [31:0] dat_o;
    logic        prog_clk, head, tail_in, prog_reset, busy;
    logic        loop_en = 1'b0, tail_drv = 1'b0;

    assign tail_in = loop_en ? head : tail_drv;

    ccff_wb_loader #(.CLK_DIV(4)) dut (
        .wb_clk_i(clk), .wb_rst_n(rst_n),
        .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_adr_i(adr), .wbs_dat_i(dat_i), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
        .prog_clk_o(prog_clk), .ccff_head_o(head), .ccff_tail_i(tail_in),
        .prog_reset_o(prog_reset), .busy_o(busy)
    );

    always #5 clk = ~clk;

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string       name;
        logic [31:0] exp;
        bit          chk;
    } exp_t;
    exp_t sb_q[$];

    int   rise_t[$];
    bit   head_seq[$];
    int   busy_cycles = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end else begin
            $display("[TB] ok   %s = 0x%08h", nm, act);
        end
    endtask

    // Scoreboard monitor: one pop per ack.
    logic ack_prev = 1'b0;
    always @(negedge clk) begin
        if (ack) begin
            chk("ack_single_cycle", {31'd0, ack_prev}, 32'd0);
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_ack: got ack with empty scoreboard expected none");
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if (e.chk) chk(e.name, dat_o, e.exp);
            end
        end
        ack_prev = ack;
    end

    logic pclk_prev = 1'b0;
    always @(negedge clk) begin
        if (prog_clk && !pclk_prev) begin
            rise_t.push_back(cyc_cnt);
            head_seq.push_back(head);
        end
        pclk_prev = prog_clk;
        if (busy) busy_cycles++;
    end

    task automatic wb(input bit w, input logic [2:0] a, input logic [31:0] d,
                      input logic [31:0] e, input bit c, input string nm,
                      input int limit, output int acc);
        exp_t x;
        x.name = nm; x.exp = e; x.chk = c;
        sb_q.push_back(x);
        stb = 1'b1; cyc = 1'b1; we = w;
        adr = {27'd0, a, 2'b00}; dat_i = d;
        acc = -1;
        for (int i = 0; i < limit; i++) begin
            @(posedge clk); #1;
            if (ack) begin
                acc = cyc_cnt;
                break;
            end
        end
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        if (acc < 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: got no ack expected ack within %0d cycles", nm, limit);
            sb_q.delete(sb_q.size() - 1);
        end
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] e, input string nm);
        int acc;
        wb(1'b0, a, 32'd0, e, 1'b1, nm, 20, acc);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        int acc;
        wb(1'b1, a, d, 32'd0, 1'b0, "wr", 20, acc);
    endtask

    task automatic wait_idle(input int limit);
        for (int i = 0; i < limit; i++) begin
            if (!busy) return;
            @(posedge clk); #1;
        end
        n_tests++;
        n_fail++;
        $display("FAIL busy_timeout: got busy=1 expected 0 within %0d cycles", limit);
    endtask

    task automatic wait_until(input int n);
        while (cyc_cnt < n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic clear_rec();
        rise_t.delete();
        head_seq.delete();
        busy_cycles = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before 500us");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0, e0b, acc;
        logic [31:0] word;
        logic [7:0]  byte_v;

        // Asynchronous reset, checked before any clock edge.
        #2 rst_n = 1'b0;
        #1;
        chk("rst_prog_clk", {31'd0, prog_clk}, 32'd0);
        chk("rst_head", {31'd0, head}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ack", {31'd0, ack}, 32'd0);
        chk("rst_dat_o", dat_o, 32'd0);
        chk("rst_prog_reset", {31'd0, prog_reset}, 32'd1);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        rd(3'd0, 32'h0000_1F01, "ctrl_reset");
        rd(3'd2, 32'd0, "status_reset");
        rd(3'd3, 32'd0, "count_reset");
        rd(3'd4, 32'd0, "tail_reset");

        // 32-bit word with tail looped back to head.
        loop_en = 1'b1;
        clear_rec();
        word = 32'hA5A5_0F0F;
        wb(1'b1, 3'd1, word, 32'd0, 1'b0, "data_a", 20, e0);
        wait_idle(400);
        chk("a_rises", 32'(rise_t.size()), 32'd32);
        chk("a_busy_cycles", 32'(busy_cycles), 32'd256);
        if (rise_t.size() > 0) chk("a_first_rise", 32'(rise_t[0]), 32'(e0 + 4));
        word = '0;
        for (int i = 0; i < 32 && i < head_seq.size(); i++) word[i] = head_seq[i];
        chk("a_head_seq", word, 32'hA5A5_0F0F);
        rd(3'd3, 32'd32, "a_count");
        rd(3'd4, 32'hA5A5_0F0F, "a_tail");
        loop_en = 1'b0;

        // 8-bit word, PROG_RST released.
        wr(3'd0, 32'h0000_0700);
        rd(3'd0, 32'h0000_0700, "b_ctrl");
        chk("b_prog_reset", {31'd0, prog_reset}, 32'd0);
        clear_rec();
        wb(1'b1, 3'd1, 32'h0000_00C3, 32'd0, 1'b0, "data_b", 20, e0);
        wait_idle(100);
        chk("b_rises", 32'(rise_t.size()), 32'd8);
        chk("b_busy_cycles", 32'(busy_cycles), 32'd64);
        byte_v = '0;
        for (int i = 0; i < 8 && i < head_seq.size(); i++) byte_v[i] = head_seq[i];
        chk("b_head_seq", {24'd0, byte_v}, 32'h0000_00C3);
        rd(3'd3, 32'd40, "b_count");
        rd(3'd4, 32'h00A5_A50F, "b_tail");

        // Back-to-back words: second write is wait-stated until IDLE.
        wr(3'd0, 32'h0000_1F00);
        wr(3'd3, 32'd0);
        rd(3'd3, 32'd0, "c_count_cleared");
        clear_rec();
        wb(1'b1, 3'd1, 32'hFFFF_0000, 32'd0, 1'b0, "data_c1", 20, e0);
        wait_until(e0 + 10);
        wb(1'b1, 3'd1, 32'h1234_5678, 32'd0, 1'b0, "data_c2", 600, e0b);
        chk("c_accept_cycle", 32'(e0b), 32'(e0 + 257));
        wait_idle(400);
        chk("c_rises", 32'(rise_t.size()), 32'd64);
        chk("c_busy_cycles", 32'(busy_cycles), 32'd512);
        if (rise_t.size() > 32) chk("c_second_first_rise", 32'(rise_t[32]), 32'(e0b + 4));

        // Abort mid-word.
        wr(3'd3, 32'd0);
        clear_rec();
        wb(1'b1, 3'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, "data_d", 20, e0);
        wait_until(e0 + 97);
        wb(1'b1, 3'd0, 32'h8000_1F00, 32'd0, 1'b0, "abort", 20, acc);
        chk("d_abort_cycle", 32'(acc), 32'(e0 + 98));
        chk("d_prog_clk", {31'd0, prog_clk}, 32'd0);
        chk("d_busy", {31'd0, busy}, 32'd0);
        chk("d_head", {31'd0, head}, 32'd0);
        rd(3'd3, 32'd12, "d_count");
        rd(3'd0, 32'h0000_1F00, "d_ctrl");
        rd(3'd2, 32'd0, "d_status");

        // COUNT clear landing on a rising prog_clk edge; unmapped reads.
        wb(1'b1, 3'd1, 32'd0, 32'd0, 1'b0, "data_e", 20, e0);
        wait_until(e0 + 11);
        wb(1'b1, 3'd3, 32'd0, 32'd0, 1'b0, "e_clr", 20, acc);
        chk("e_clr_cycle", 32'(acc), 32'(e0 + 12));
        rd(3'd3, 32'd0, "e_count_clear_wins");
        rd(3'd2, 32'd1, "e_status_busy");
        rd(3'd6, 32'hDEAD_BEEF, "e_adr6");
        wr(3'd7, 32'h0000_0000);
        rd(3'd1, 32'hDEAD_BEEF, "e_adr1");
        wr(3'd0, 32'h8000_1F00);

        // Reset in the middle of a word (prog_clk high at this point).
        wb(1'b1, 3'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, "data_f", 20, e0);
        wait_until(e0 + 30);
        rst_n = 1'b0;
        #1;
        chk("f_prog_clk", {31'd0, prog_clk}, 32'd0);
        chk("f_busy", {31'd0, busy}, 32'd0);
        chk("f_head", {31'd0, head}, 32'd0);
        chk("f_ack", {31'd0, ack}, 32'd0);
        chk("f_dat_o", dat_o, 32'd0);
        chk("f_prog_reset", {31'd0, prog_reset}, 32'd1);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        clear_rec();
        repeat (50) @(posedge clk);
        #1;
        chk("f_no_rise_after_release", 32'(rise_t.size()), 32'd0);
        rd(3'd0, 32'h0000_1F01, "f_ctrl");
        rd(3'd3, 32'd0, "f_count");
        rd(3'd4, 32'd0, "f_tail");

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
